apb_reg_file: RTL and testbench
===============================

Name: apb_reg_file

Overview:
- Register file that sits directly downstream of the APB slave front-end.
- Consumes its decoded register-file strobes: addr, write_en, read_en, byte_strobe, wdata.
- Holds a small register map: CTRL (RW), STATUS (RO, hardware-fed), INT_STAT (W1C, hardware-set), INT_EN (RW), plus scratch registers.
- Returns read data with a one-cycle valid pulse, flags illegal accesses, and drives a level interrupt.

Parameters:
- DATA_WIDTH, 32, register and data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- NBYTES, DATA_WIDTH/8, number of byte lanes.
- NUM_REGS, 8, number of word registers; must be ≥ 5.
- CTRL_RST, 0, reset value of CTRL.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- addr  in  ADDR_WIDTH  byte address of the access.
- write_en  in  1  write request; one access per cycle it is high.
- read_en  in  1  read request; one access per cycle it is high.
- byte_strobe  in  NBYTES  write byte-lane enables.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; valid while rvalid is high.
- rvalid  out  1  one-cycle pulse, one cycle after any accepted access (read or write).
- err  out  1  one-cycle error flag, coincident with rvalid.
- hw_status  in  DATA_WIDTH  live status, sampled into STATUS every cycle.
- hw_event  in  DATA_WIDTH  per-bit set pulses for INT_STAT.
- ctrl_out  out  DATA_WIDTH  current CTRL contents.
- irq  out  1  registered value of |(INT_STAT & INT_EN).

Behaviour:
- Reset (asynchronous, PRESETn low):
  - CTRL = CTRL_RST; STATUS, INT_STAT, INT_EN and scratch registers = 0.
  - rdata = 0, rvalid = 0, err = 0, irq = 0.
  - Reset asserted mid-access discards that access; no rvalid follows.
- Index decode:
  - idx = addr >> log2(NBYTES).
  - Map: idx 0 CTRL, 1 STATUS, 2 INT_STAT, 3 INT_EN, 4..NUM_REGS-1 scratch.
- Illegal access, flagged with err = 1 on the response:
  - misaligned: addr[log2(NBYTES)-1:0] != 0;
  - out of range: idx ≥ NUM_REGS;
  - write to STATUS.
- Illegal writes modify nothing. Illegal reads return rdata = 0.
- Write (write_en = 1, legal): the register updates at the same edge.
  - RW registers: byte lane i is replaced by wdata lane i only if byte_strobe[i] = 1.
  - INT_STAT (W1C): bit b clears if its lane strobe is 1 and wdata[b] = 1.
  - byte_strobe = 0 gives a legal no-op; err = 0.
- Read (read_en = 1, legal): next cycle rdata = register value as of the request edge, rvalid = 1, err = 0.
- Write response: one cycle later rvalid = 1, rdata = 0, err as decoded.
- write_en and read_en both high in one cycle:
  - performed as the write only;
  - response carries err = 1, rdata = 0.
- Back-to-back accesses:
  - one access per cycle, each answered exactly one cycle later;
  - a read immediately following a write to the same register returns the new value.
- Latency: fixed, one cycle. No backpressure.
- STATUS: reloaded from hw_status every cycle; a read returns the value captured at the edge before the request edge.
- INT_STAT:
  - each cycle, INT_STAT |= hw_event;
  - when a hw_event set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq: registered; it reflects INT_STAT/INT_EN one cycle after they change.
- ctrl_out: driven directly from the CTRL register.

Decomposition:
- Package apb_reg_pkg holds:
  - register index constants: IDX_CTRL = 0, IDX_STATUS = 1, IDX_INT_STAT = 2, IDX_INT_EN = 3, IDX_SCRATCH0 = 4;
  - access-type enum {ACC_RW, ACC_RO, ACC_W1C};
  - a function returning the access type for an index.
- Sub-module apb_reg_strobe_merge: combinational byte-lane merge (old, wdata, byte_strobe, w1c_mode → new). One instance is shared by all registers through a decode mux.

Test Plan:
- Reset, then read idx 0 with CTRL_RST = 32'h0000_00A5 → next cycle rdata = 32'h0000_00A5, rvalid = 1, err = 0; irq = 0.
- Write CTRL = 32'hDEAD_BEEF with byte_strobe = 4'b0101 over 32'h1111_1111, then read → 32'h11AD_11EF; ctrl_out matches the cycle after the write.
- hw_event bit 3 pulse; INT_EN = 32'h8 → irq rises within 2 cycles. W1C write 32'h8 (strobe 4'hF) → irq falls. Repeat with hw_event bit 3 in the same cycle as the W1C → bit stays set, irq stays 1.
- Illegal accesses: addr 32'h0000_0002 (misaligned), idx 8 (addr 32'h20), write to STATUS, write_en and read_en both high → each gives rvalid = 1, err = 1, rdata = 0; no register changes, confirmed by read-back.
- Back-to-back: write scratch idx 4 = 32'hCAFE_F00D, read idx 4 next cycle → rdata = 32'hCAFE_F00D. Drive hw_status = 32'h1234_5678, read idx 1 → 32'h1234_5678.
- Assert PRESETn low in the cycle after a read request → rvalid stays 0, all registers return to reset values, and the first access after release behaves normally.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared register-map constants and access-type decode for the APB register file.
package apb_reg_pkg;

  localparam int unsigned IDX_CTRL     = 0;
  localparam int unsigned IDX_STATUS   = 1;
  localparam int unsigned IDX_INT_STAT = 2;
  localparam int unsigned IDX_INT_EN   = 3;
  localparam int unsigned IDX_SCRATCH0 = 4;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_e;

  // Access behaviour of each word register; everything not listed is plain RW.
  function automatic acc_e reg_access(input int unsigned idx);
    case (idx)
      IDX_STATUS:   return ACC_RO;
      IDX_INT_STAT: return ACC_W1C;
      default:      return ACC_RW;
    endcase
  endfunction

endpackage

// File: rtl/apb_reg_strobe_merge.sv
// Combinational byte-lane merge of write data into an existing register value.
// In w1c_mode a strobed lane clears the bits that are set in wdata instead of replacing them.
module apb_reg_strobe_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NBYTES     = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NBYTES-1:0]     byte_strobe,
  input  logic                  w1c_mode,
  output logic [DATA_WIDTH-1:0] new_val
);

  // Per-lane replace or clear-on-one.
  always_comb begin
    new_val = old_val;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_strobe[i]) begin
        if (w1c_mode) begin
          new_val[i*8 +: 8] = old_val[i*8 +: 8] & ~wdata[i*8 +: 8];
        end else begin
          new_val[i*8 +: 8] = wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb_reg_file.sv
// Register file behind the APB slave front-end: CTRL, STATUS, INT_STAT, INT_EN and scratch
// registers, a one-cycle registered response, and a level interrupt.
module apb_reg_file
  import apb_reg_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           NBYTES     = DATA_WIDTH / 8,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] CTRL_RST   = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [NBYTES-1:0]     byte_strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  err,
  input  logic [DATA_WIDTH-1:0] hw_status,
  input  logic [DATA_WIDTH-1:0] hw_event,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic                  irq
);

  localparam int unsigned LSB = $clog2(NBYTES);
  localparam int unsigned IW  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0] idx;
  logic [IW-1:0]         sel;
  acc_e                  sel_type;
  logic                  misaligned, out_of_range, access;
  logic                  wr_ok, rd_ok, err_d;
  logic [DATA_WIDTH-1:0] merged, rdata_d;

  assign idx          = addr >> LSB;
  assign sel          = idx[IW-1:0];
  assign sel_type     = reg_access(32'(sel));
  // Mask form keeps the alignment check valid even for a single byte lane.
  assign misaligned   = (addr & ADDR_WIDTH'(NBYTES - 1)) != '0;
  assign out_of_range = idx >= ADDR_WIDTH'(NUM_REGS);
  assign access       = write_en | read_en;

  // Access legality; a simultaneous read is dropped and the write still goes through.
  always_comb begin
    wr_ok   = write_en & ~misaligned & ~out_of_range & (sel_type != ACC_RO);
    rd_ok   = read_en & ~write_en & ~misaligned & ~out_of_range;
    err_d   = access & (misaligned | out_of_range | (write_en & (sel_type == ACC_RO)) |
                        (write_en & read_en));
    rdata_d = rd_ok ? regs_q[sel] : '0;
  end

  apb_reg_strobe_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .NBYTES     (NBYTES)
  ) u_merge (
    .old_val     (regs_q[sel]),
    .wdata       (wdata),
    .byte_strobe (byte_strobe),
    .w1c_mode    (sel_type == ACC_W1C),
    .new_val     (merged)
  );

  // Next register state: bus write, then hardware status reload and event sets (set wins).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[sel] = merged;
    end
    regs_d[IDX_STATUS]   = hw_status;
    regs_d[IDX_INT_STAT] = regs_d[IDX_INT_STAT] | hw_event;
  end

  // Register storage.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[IDX_CTRL] <= CTRL_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // One-cycle response and registered interrupt.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
    end else begin
      rvalid <= access;
      err    <= err_d;
      rdata  <= rdata_d;
      irq    <= |(regs_q[IDX_INT_STAT] & regs_q[IDX_INT_EN]);
    end
  end

  assign ctrl_out = regs_q[IDX_CTRL];

endmodule

// File: tb/tb_apb_reg_file.sv
// Directed self-checking bench for apb_reg_file.
module tb_apb_reg_file;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] addr;
  logic        write_en, read_en;
  logic [3:0]  byte_strobe;
  logic [31:0] wdata, rdata, hw_status, hw_event, ctrl_out;
  logic        rvalid, err, irq;

  int checks = 0;
  int errors = 0;

  apb_reg_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NBYTES     (4),
    .NUM_REGS   (8),
    .CTRL_RST   (32'h0000_00A5)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .addr        (addr),
    .write_en    (write_en),
    .read_en     (read_en),
    .byte_strobe (byte_strobe),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .err         (err),
    .hw_status   (hw_status),
    .hw_event    (hw_event),
    .ctrl_out    (ctrl_out),
    .irq         (irq)
  );

  always #5 PCLK = ~PCLK;

  // Called at a negedge: apply one cycle of bus inputs, return at the next negedge.
  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    write_en = we; read_en = re; addr = a; byte_strobe = s; wdata = d;
    @(negedge PCLK);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Read and compare the full response {rvalid, err, rdata}.
  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, 4'h0, 32'h0);
    checks++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, exp}) begin
      errors++;
      $display("FAIL %s: got rvalid=%b err=%b rdata=%h, want 1/0/%h", name, rvalid, err, rdata,
               exp);
    end
    idle();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; hw_status = 32'h0; hw_event = 32'h0;
    write_en = 0; read_en = 0; addr = 0; byte_strobe = 0; wdata = 0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({rvalid, err, rdata, irq, ctrl_out} !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL reset_state: got rv=%b err=%b rdata=%h irq=%b ctrl=%h, want 0/0/0/0/a5",
               rvalid, err, rdata, irq, ctrl_out);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    read_chk("reset_ctrl_read", 32'h0, 32'h0000_00A5);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_strobe();
    drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h1111_1111);
    idle();
    drive(1'b1, 1'b0, 32'h0, 4'b0101, 32'hDEAD_BEEF);
    checks++;
    if ({rvalid, err, rdata, ctrl_out} !== {1'b1, 1'b0, 32'h0, 32'h11AD_11EF}) begin
      errors++;
      $display("FAIL strobe_write_resp: got rv=%b err=%b rdata=%h ctrl=%h, want 1/0/0/11ad11ef",
               rvalid, err, rdata, ctrl_out);
    end
    idle();
    read_chk("strobe_readback", 32'h0, 32'h11AD_11EF);
  endtask

  task automatic test_irq();
    drive(1'b1, 1'b0, 32'hC, 4'hF, 32'h0000_0008);
    hw_event = 32'h8; idle(); hw_event = 32'h0;
    idle();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b want 1", irq);
    end
    read_chk("int_stat_set", 32'h8, 32'h0000_0008);
    drive(1'b1, 1'b0, 32'h8, 4'hF, 32'h0000_0008);
    idle();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_fall: got %b want 0", irq);
    end
    read_chk("int_stat_cleared", 32'h8, 32'h0);
    // Set and clear of the same bit in one cycle: the set wins.
    hw_event = 32'h8; idle(); hw_event = 32'h0;
    idle();
    hw_event = 32'h8; drive(1'b1, 1'b0, 32'h8, 4'hF, 32'h0000_0008); hw_event = 32'h0;
    idle();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_set_wins: got %b want 1", irq);
    end
    read_chk("int_stat_set_wins", 32'h8, 32'h0000_0008);
    drive(1'b1, 1'b0, 32'h8, 4'hF, 32'h0000_0008);
    idle();
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b0, 32'h14, 4'hF, 32'h5555_AAAA);
    idle();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(1'b1, 1'b0, 32'h2,  4'hF, 32'hFFFF_FFFF); // misaligned write
        1: drive(1'b0, 1'b1, 32'h2,  4'h0, 32'h0);         // misaligned read
        2: drive(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);         // out-of-range read
        3: drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);         // out-of-range write
        4: drive(1'b1, 1'b0, 32'h4,  4'hF, 32'hFFFF_FFFF); // write to STATUS
        default: drive(1'b1, 1'b1, 32'h14, 4'hF, 32'h5555_AAAA); // write and read together
      endcase
      checks++;
      if ({rvalid, err, rdata} !== {1'b1, 1'b1, 32'h0}) begin
        errors++;
        $display("FAIL illegal_%0d: got rv=%b err=%b rdata=%h, want 1/1/0", k, rvalid, err,
                 rdata);
      end
      idle();
    end
    read_chk("illegal_ctrl_unchanged", 32'h0, 32'h11AD_11EF);
    read_chk("illegal_status_unchanged", 32'h4, 32'h0);
    read_chk("illegal_scratch_unchanged", 32'h14, 32'h5555_AAAA);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'hCAFE_F00D);
    checks++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL b2b_write_resp: got rv=%b err=%b rdata=%h, want 1/0/0", rvalid, err, rdata);
    end
    drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
    checks++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL b2b_read: got rv=%b err=%b rdata=%h, want 1/0/cafef00d", rvalid, err, rdata);
    end
    idle();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_rvalid_drop: got %b want 0", rvalid);
    end
    hw_status = 32'h1234_5678;
    idle();
    read_chk("status_read", 32'h4, 32'h1234_5678);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h0000_0077);
    write_en = 0; read_en = 1; addr = 32'h0; byte_strobe = 0; wdata = 0;
    @(posedge PCLK);
    #1 PRESETn = 1'b0;
    read_en = 0;
    @(negedge PCLK);
    checks++;
    if ({rvalid, ctrl_out} !== {1'b0, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL reset_mid: got rv=%b ctrl=%h, want 0/000000a5", rvalid, ctrl_out);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    read_chk("post_reset_ctrl", 32'h0, 32'h0000_00A5);
    read_chk("post_reset_int_en", 32'hC, 32'h0);
    read_chk("post_reset_scratch", 32'h10, 32'h0);
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_irq();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
